// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the serial adder/subtractor: FSM state encoding and a
// constant-evaluable ceiling-log2 used to size the digit counter.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple adder built from full_adder cells; also exposes the carry
// into its top bit so the caller can form signed overflow on the last digit.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the digit ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor processing DIGIT bits per clock, LSB digit first,
// with a start/busy/done handshake and a result held until the next completion.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start_in,
    input  logic             sub_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             overflow_out
);

    localparam int NCYC = WIDTH / DIGIT;
    localparam int CW   = (clog2(NCYC) < 1) ? 1 : clog2(NCYC);

    state_t state, next_state;

    logic [WIDTH-1:0]       a_sh, b_sh, res_sh;
    logic                   carry_q;
    logic [CW-1:0]          cnt;
    logic [DIGIT-1:0]       d_sum;
    logic                   d_cout, d_cmsb;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_next;
    logic                   last_digit;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a     (a_sh[DIGIT-1:0]),
        .b     (b_sh[DIGIT-1:0]),
        .cin   (carry_q),
        .sum   (d_sum),
        .cout  (d_cout),
        .c_msb (d_cmsb)
    );

    // New digit enters at the MSB end; the concatenation keeps DIGIT==WIDTH legal.
    assign res_cat    = {d_sum, res_sh};
    assign res_next   = res_cat[WIDTH+DIGIT-1:DIGIT];
    assign last_digit = (cnt == CW'(NCYC - 1));
    assign busy_out   = (state == RUN) || (state == DONE);

    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_in) next_state = RUN;
            RUN:     if (last_digit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Subtraction is a + ~b with the carry-in inverted, so the add path is shared.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            a_sh         <= '0;
            b_sh         <= '0;
            res_sh       <= '0;
            carry_q      <= 1'b0;
            cnt          <= '0;
            sum_out      <= '0;
            carry_out    <= 1'b0;
            overflow_out <= 1'b0;
            done_out     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        a_sh    <= a_in;
                        b_sh    <= sub_in ? ~b_in : b_in;
                        carry_q <= c_in ^ sub_in;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> DIGIT;
                    b_sh    <= b_sh >> DIGIT;
                    res_sh  <= res_next;
                    carry_q <= d_cout;
                    cnt     <= cnt + 1'b1;
                    if (last_digit) begin
                        sum_out      <= res_next;
                        carry_out    <= d_cout;
                        overflow_out <= d_cmsb ^ d_cout;
                        done_out     <= 1'b1;
                    end
                end
                DONE:    done_out <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: a bit-serial (DIGIT=1) and a DIGIT=4
// instance checked against a signed/unsigned integer arithmetic model.
module tb_serial_addsub;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start1 = 1'b0, start4 = 1'b0;
    logic       sub_in = 1'b0, c_in = 1'b0;
    logic [7:0] a_in = '0, b_in = '0;

    logic       busy1, done1, carry1, ovf1;
    logic [7:0] sum1;
    logic       busy4, done4, carry4, ovf4;
    logic [7:0] sum4;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clock(clock), .resetn(resetn), .start_in(start1), .sub_in(sub_in),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .busy_out(busy1), .done_out(done1),
        .sum_out(sum1), .carry_out(carry1), .overflow_out(ovf1)
    );

    serial_addsub #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clock(clock), .resetn(resetn), .start_in(start4), .sub_in(sub_in),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .busy_out(busy4), .done_out(done4),
        .sum_out(sum4), .carry_out(carry4), .overflow_out(ovf4)
    );

    function automatic logic [7:0] obs_sum(input bit sel);   return sel ? sum4 : sum1;     endfunction
    function automatic logic       obs_carry(input bit sel); return sel ? carry4 : carry1; endfunction
    function automatic logic       obs_ovf(input bit sel);   return sel ? ovf4 : ovf1;     endfunction
    function automatic logic       obs_busy(input bit sel);  return sel ? busy4 : busy1;   endfunction
    function automatic logic       obs_done(input bit sel);  return sel ? done4 : done1;   endfunction

    // Reference: plain integer arithmetic, unsigned for carry, signed for overflow.
    task automatic ref_model(input logic [7:0] a, b, input logic sub, c,
                             output logic [7:0] s, output logic co, ov);
        int ua, ub, sa, sb, ci, ur, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ci = int'(c);
        if (sub) begin
            ur = ua - ub - ci;
            sr = sa - sb - ci;
            co = (ur >= 0);
        end else begin
            ur = ua + ub + ci;
            sr = sa + sb + ci;
            co = (ur > 255);
        end
        s  = ur[7:0];
        ov = (sr > 127) || (sr < -128);
    endtask

    // Runs one operation and reports what the DUT did; inj_k/inj_done pulse a stray start.
    task automatic do_op(input bit sel, input logic [7:0] a, b, input logic sub, c,
                         input int inj_k, input bit inj_done,
                         output logic [7:0] s, output logic co, ov,
                         output int lat, busy_n, done_n, output bit stable, output int acc_cyc);
        logic [7:0] ps;
        logic pc, pv;
        bit got, drive;
        ps = obs_sum(sel);
        pc = obs_carry(sel);
        pv = obs_ovf(sel);
        @(negedge clock);
        a_in = a; b_in = b; sub_in = sub; c_in = c;
        start1 = !sel; start4 = sel;
        @(posedge clock); #1;
        start1 = 1'b0; start4 = 1'b0;
        acc_cyc = cyc;
        lat = 1; busy_n = 0; done_n = 0; stable = 1'b1; got = 1'b0;
        s = 'x; co = 1'bx; ov = 1'bx;
        for (int k = 0; k < 40; k++) begin
            if (obs_busy(sel)) busy_n++;
            if (obs_done(sel)) begin
                done_n++;
                if (!got) begin
                    got = 1'b1;
                    s = obs_sum(sel); co = obs_carry(sel); ov = obs_ovf(sel);
                end
            end else if (!got && (obs_sum(sel) !== ps || obs_carry(sel) !== pc || obs_ovf(sel) !== pv)) begin
                stable = 1'b0;
            end
            if (got && !obs_busy(sel)) break;
            drive = (k == inj_k) || (inj_done && obs_done(sel));
            if (drive) begin
                a_in = 8'($urandom); b_in = 8'($urandom);
                sub_in = 1'($urandom); c_in = 1'($urandom);
            end
            start1 = drive && !sel;
            start4 = drive && sel;
            @(posedge clock); #1;
            if (!got) lat++;
        end
        start1 = 1'b0; start4 = 1'b0;
        if (!got) lat = -1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start1 = 1'b0; start4 = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (busy1 !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy1 got=%b exp=0", busy1); end
        checks++; if (done1 !== 1'b0) begin failures++; $display("[TB] FAIL rst_done1 got=%b exp=0", done1); end
        checks++; if (sum1 !== 8'h00) begin failures++; $display("[TB] FAIL rst_sum1 got=%h exp=00", sum1); end
        checks++; if ({carry1, ovf1} !== 2'b00) begin failures++; $display("[TB] FAIL rst_flags1 got=%b exp=00", {carry1, ovf1}); end
        checks++; if ({busy4, done4, carry4, ovf4} !== 4'b0) begin failures++; $display("[TB] FAIL rst_ctl4 got=%b exp=0000", {busy4, done4, carry4, ovf4}); end
        checks++; if (sum4 !== 8'h00) begin failures++; $display("[TB] FAIL rst_sum4 got=%h exp=00", sum4); end
        @(negedge clock);
        resetn = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if ({busy1, done1, carry1, ovf1} !== 4'b0) begin failures++; $display("[TB] FAIL idle_ctl1 got=%b exp=0000", {busy1, done1, carry1, ovf1}); end
        checks++; if (sum1 !== 8'h00) begin failures++; $display("[TB] FAIL idle_sum1 got=%h exp=00", sum1); end
        checks++; if ({busy4, done4} !== 2'b00) begin failures++; $display("[TB] FAIL idle_ctl4 got=%b exp=00", {busy4, done4}); end
    endtask

    task automatic test_add_d1();
        logic [7:0] va [4] = '{8'hFF, 8'h7F, 8'h05, 8'h80};
        logic [7:0] vb [4] = '{8'h01, 8'h01, 8'h07, 8'h01};
        logic       vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] s, es;
        logic co, ov, eco, eov;
        int lat, bn, dn, acc;
        bit st;
        for (int i = 0; i < 4; i++) begin
            do_op(1'b0, va[i], vb[i], vs[i], 1'b0, -1, 1'b0, s, co, ov, lat, bn, dn, st, acc);
            ref_model(va[i], vb[i], vs[i], 1'b0, es, eco, eov);
            checks++; if (s !== es) begin failures++; $display("[TB] FAIL d1_sum[%0d] got=%h exp=%h", i, s, es); end
            checks++; if (co !== eco) begin failures++; $display("[TB] FAIL d1_carry[%0d] got=%b exp=%b", i, co, eco); end
            checks++; if (ov !== eov) begin failures++; $display("[TB] FAIL d1_ovf[%0d] got=%b exp=%b", i, ov, eov); end
            checks++; if (lat !== 9) begin failures++; $display("[TB] FAIL d1_latency[%0d] got=%0d exp=9", i, lat); end
            checks++; if (bn !== 9) begin failures++; $display("[TB] FAIL d1_busy_cycles[%0d] got=%0d exp=9", i, bn); end
            checks++; if (dn !== 1) begin failures++; $display("[TB] FAIL d1_done_width[%0d] got=%0d exp=1", i, dn); end
            checks++; if (st !== 1'b1) begin failures++; $display("[TB] FAIL d1_hold_during_run[%0d] got=%b exp=1", i, st); end
        end
    endtask

    task automatic test_digit4();
        logic [7:0] s;
        logic co, ov;
        int lat, bn, dn, acc;
        bit st;
        do_op(1'b1, 8'h3C, 8'hC4, 1'b0, 1'b1, -1, 1'b0, s, co, ov, lat, bn, dn, st, acc);
        checks++; if (s !== 8'h01) begin failures++; $display("[TB] FAIL d4_sum got=%h exp=01", s); end
        checks++; if (co !== 1'b1) begin failures++; $display("[TB] FAIL d4_carry got=%b exp=1", co); end
        checks++; if (ov !== 1'b0) begin failures++; $display("[TB] FAIL d4_ovf got=%b exp=0", ov); end
        checks++; if (lat !== 3) begin failures++; $display("[TB] FAIL d4_latency got=%0d exp=3", lat); end
        checks++; if (bn !== 3) begin failures++; $display("[TB] FAIL d4_busy_cycles got=%0d exp=3", bn); end
        checks++; if (dn !== 1) begin failures++; $display("[TB] FAIL d4_done_width got=%0d exp=1", dn); end
    endtask

    task automatic test_random();
        logic [7:0] a, b, s, es;
        logic sub, c, co, ov, eco, eov;
        bit sel, st;
        int lat, bn, dn, acc;
        for (int i = 0; i < 24; i++) begin
            sel = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            sub = 1'($urandom); c = 1'($urandom);
            do_op(sel, a, b, sub, c, -1, 1'b0, s, co, ov, lat, bn, dn, st, acc);
            ref_model(a, b, sub, c, es, eco, eov);
            checks++; if ({s, co, ov} !== {es, eco, eov})
                begin failures++; $display("[TB] FAIL rand[%0d] sel=%0d a=%h b=%h sub=%b c=%b got=%h/%b/%b exp=%h/%b/%b", i, sel, a, b, sub, c, s, co, ov, es, eco, eov); end
            checks++; if (lat !== (sel ? 3 : 9)) begin failures++; $display("[TB] FAIL rand_latency[%0d] got=%0d exp=%0d", i, lat, sel ? 3 : 9); end
        end
    endtask

    task automatic test_ignored_start();
        logic [7:0] s, es;
        logic co, ov, eco, eov;
        int lat, bn, dn, acc;
        bit st;
        do_op(1'b0, 8'h5A, 8'h33, 1'b1, 1'b1, 3, 1'b1, s, co, ov, lat, bn, dn, st, acc);
        ref_model(8'h5A, 8'h33, 1'b1, 1'b1, es, eco, eov);
        checks++; if ({s, co, ov} !== {es, eco, eov}) begin failures++; $display("[TB] FAIL ignore_result got=%h/%b/%b exp=%h/%b/%b", s, co, ov, es, eco, eov); end
        checks++; if (dn !== 1) begin failures++; $display("[TB] FAIL ignore_done_count got=%0d exp=1", dn); end
        checks++; if (bn !== 9) begin failures++; $display("[TB] FAIL ignore_busy_cycles got=%0d exp=9", bn); end
        @(posedge clock); #1;
        checks++; if (busy1 !== 1'b0) begin failures++; $display("[TB] FAIL ignore_idle_after got=%b exp=0", busy1); end
        checks++; if (sum1 !== es) begin failures++; $display("[TB] FAIL ignore_hold got=%h exp=%h", sum1, es); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s, es;
        logic co, ov, eco, eov;
        int lat, bn, dn, acc1, acc2;
        bit st;
        do_op(1'b0, 8'h11, 8'h22, 1'b0, 1'b0, -1, 1'b0, s, co, ov, lat, bn, dn, st, acc1);
        do_op(1'b0, 8'hF0, 8'h0F, 1'b0, 1'b1, -1, 1'b0, s, co, ov, lat, bn, dn, st, acc2);
        ref_model(8'hF0, 8'h0F, 1'b0, 1'b1, es, eco, eov);
        checks++; if (acc2 - acc1 !== 10) begin failures++; $display("[TB] FAIL b2b_d1_spacing got=%0d exp=10", acc2 - acc1); end
        checks++; if ({s, co, ov} !== {es, eco, eov}) begin failures++; $display("[TB] FAIL b2b_d1_result got=%h/%b/%b exp=%h/%b/%b", s, co, ov, es, eco, eov); end
        do_op(1'b1, 8'h01, 8'h02, 1'b1, 1'b0, -1, 1'b0, s, co, ov, lat, bn, dn, st, acc1);
        do_op(1'b1, 8'h9C, 8'h9C, 1'b0, 1'b0, -1, 1'b0, s, co, ov, lat, bn, dn, st, acc2);
        ref_model(8'h9C, 8'h9C, 1'b0, 1'b0, es, eco, eov);
        checks++; if (acc2 - acc1 !== 4) begin failures++; $display("[TB] FAIL b2b_d4_spacing got=%0d exp=4", acc2 - acc1); end
        checks++; if ({s, co, ov} !== {es, eco, eov}) begin failures++; $display("[TB] FAIL b2b_d4_result got=%h/%b/%b exp=%h/%b/%b", s, co, ov, es, eco, eov); end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] s;
        logic co, ov;
        int lat, bn, dn, acc;
        bit st, saw_activity;
        do_op(1'b0, 8'hC0, 8'hC0, 1'b0, 1'b0, -1, 1'b0, s, co, ov, lat, bn, dn, st, acc);
        @(negedge clock);
        a_in = 8'h55; b_in = 8'h22; sub_in = 1'b0; c_in = 1'b1; start1 = 1'b1;
        @(posedge clock); #1;
        start1 = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetn = 1'b0;
        @(posedge clock); #1;
        checks++; if ({busy1, done1} !== 2'b00) begin failures++; $display("[TB] FAIL midrst_ctl got=%b exp=00", {busy1, done1}); end
        checks++; if ({sum1, carry1, ovf1} !== 10'b0) begin failures++; $display("[TB] FAIL midrst_outputs got=%h/%b/%b exp=00/0/0", sum1, carry1, ovf1); end
        @(negedge clock);
        resetn = 1'b1;
        saw_activity = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clock); #1;
            if (done1 || busy1) saw_activity = 1'b1;
        end
        checks++; if (saw_activity !== 1'b0) begin failures++; $display("[TB] FAIL midrst_no_done got=%b exp=0", saw_activity); end
        checks++; if (sum1 !== 8'h00) begin failures++; $display("[TB] FAIL midrst_sum_after got=%h exp=00", sum1); end
    endtask

    initial begin
        test_reset();
        test_add_d1();
        test_digit4();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
